// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: descriptor layout, sequencer states and a saturating increment shared by the layer sequencer.
package layer_seq_pkg;
    localparam int LAYER_DESC_W = 41;
    typedef struct packed {
        logic [4:0] out_ch;
        logic [8:0] src_a_max;
        logic [8:0] dst_a_max;
        logic [9:0] w_max;
        logic [7:0] b_max;
    } layer_desc_t;
    typedef enum logic [2:0] {IDLE, LOAD, GAP, RUN, DRAIN, DONE} seq_state_e;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/layer_seq_if.sv
// layer_seq_if: command, control and stream-monitor bundle of the layer sequencer.
// LAYER_SEQ_PERF_EN adds the perf_cyc/perf_stall counters.
interface layer_seq_if;
    import layer_seq_pkg::*;
    logic        abort, cmd_valid, cmd_ready;
    layer_desc_t cmd_desc;
    logic [4:0]  out_ch;
    logic [8:0]  src_a_max, dst_a_max;
    logic        matw, run, last;
    logic        src_valid, src_ready, dst_valid, dst_ready;
    logic        busy, layer_done, ovr;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] perf_cyc, perf_stall;
    modport master (output abort, cmd_valid, cmd_desc, src_valid, src_ready, dst_valid, dst_ready,
                    input cmd_ready, out_ch, src_a_max, dst_a_max, matw, run, last, busy, layer_done, ovr,
                    perf_cyc, perf_stall);
    modport slave (input abort, cmd_valid, cmd_desc, src_valid, src_ready, dst_valid, dst_ready,
                   output cmd_ready, out_ch, src_a_max, dst_a_max, matw, run, last, busy, layer_done, ovr,
                   perf_cyc, perf_stall);
`else
    modport master (output abort, cmd_valid, cmd_desc, src_valid, src_ready, dst_valid, dst_ready,
                    input cmd_ready, out_ch, src_a_max, dst_a_max, matw, run, last, busy, layer_done, ovr);
    modport slave (input abort, cmd_valid, cmd_desc, src_valid, src_ready, dst_valid, dst_ready,
                   output cmd_ready, out_ch, src_a_max, dst_a_max, matw, run, last, busy, layer_done, ovr);
`endif
endinterface

// File: rtl/layer_seq_fifo.sv
// desc_fifo: show-ahead descriptor FIFO with flush; full is registered so it reads as 1 while in reset.
module desc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 41
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_flush,
    input  logic         i_wr,
    input  logic [W-1:0] i_din,
    input  logic         i_rd,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt, w_cnt_nx;
    logic          r_full, w_wr, w_rd;
    assign w_wr     = i_wr & ~r_full;
    assign w_rd     = i_rd & ~o_empty;
    assign w_cnt_nx = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    assign o_empty  = r_cnt == '0;
    assign o_full   = r_full;
    assign o_dout   = r_mem[r_rp];
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wp] <= i_din;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b1;
        end else if (i_flush) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_wp   <= r_wp + AW'(w_wr);
            r_rp   <= r_rp + AW'(w_rd);
            r_cnt  <= w_cnt_nx;
            r_full <= w_cnt_nx == (AW+1)'(DEPTH);
        end
endmodule

// File: rtl/layer_seq.sv
// layer_seq: queues layer descriptors and steps each layer through LOAD/GAP/RUN/DRAIN/DONE.
// LAYER_SEQ_PERF_EN adds per-layer cycle and input-stall counters.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int BW    = 8
) (
    input logic        clk,
    input logic        reset_n,
    layer_seq_if.slave bus
);
    seq_state_e  r_st;
    logic        r_matw, r_run, r_last, r_busy, r_done, r_ovr;
    logic [4:0]  r_out_ch;
    logic [8:0]  r_src_max, r_dst_max, r_in_cnt, r_out_cnt;
    logic [9:0]  r_w_max, r_w_cnt;
    logic [BW-1:0] r_b_max, r_b_in, r_b_out, w_b_in_nx;
    layer_desc_t w_head;
    logic        w_full, w_empty, w_pop, w_act, w_in_beat, w_out_beat, w_out_wrap, w_to_done;

    desc_fifo #(.DEPTH(DEPTH), .W(LAYER_DESC_W)) u_fifo (
        .clk(clk), .reset_n(reset_n), .i_flush(bus.abort),
        .i_wr(bus.cmd_valid & ~w_full), .i_din(bus.cmd_desc), .i_rd(w_pop),
        .o_dout(w_head), .o_full(w_full), .o_empty(w_empty)
    );

    assign w_act      = (r_st == RUN) || (r_st == DRAIN);
    assign w_pop      = (r_st == IDLE) & ~w_empty & ~bus.abort;
    assign w_in_beat  = bus.src_valid & bus.src_ready;
    assign w_out_beat = w_act & bus.dst_valid & bus.dst_ready;
    assign w_out_wrap = w_out_beat & (r_out_cnt == r_dst_max);
    assign w_to_done  = w_out_wrap & (r_b_out == r_b_max) & ~bus.abort;
    assign w_b_in_nx  = r_b_in + BW'(1);

    // The output-side completion is evaluated last so it wins over an input wrap in the same cycle.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_st <= IDLE;
            {r_matw, r_run, r_last, r_busy, r_done, r_ovr} <= '0;
            {r_out_ch, r_src_max, r_dst_max, r_w_max, r_b_max} <= '0;
            {r_w_cnt, r_in_cnt, r_out_cnt, r_b_in, r_b_out} <= '0;
        end else if (bus.abort) begin
            r_st <= IDLE;
            {r_matw, r_run, r_last, r_busy, r_done, r_ovr} <= '0;
            {r_w_cnt, r_in_cnt, r_out_cnt, r_b_in, r_b_out} <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_st)
                IDLE: if (w_pop) begin
                    r_st      <= LOAD;
                    r_matw    <= 1'b1;
                    r_busy    <= 1'b1;
                    r_out_ch  <= w_head.out_ch;
                    r_src_max <= w_head.src_a_max;
                    r_dst_max <= w_head.dst_a_max;
                    r_w_max   <= w_head.w_max;
                    r_b_max   <= BW'(w_head.b_max);
                    {r_w_cnt, r_in_cnt, r_out_cnt, r_b_in, r_b_out} <= '0;
                end
                LOAD: if (bus.src_valid) begin
                    r_w_cnt <= r_w_cnt + 10'd1;
                    if (r_w_cnt == r_w_max) begin
                        r_st   <= GAP;
                        r_matw <= 1'b0;
                    end
                end
                GAP: begin
                    r_st   <= RUN;
                    r_run  <= 1'b1;
                    r_last <= r_b_max == '0;
                end
                RUN, DRAIN: begin
                    if (w_in_beat && r_st == DRAIN) r_ovr <= 1'b1;
                    else if (w_in_beat) begin
                        r_in_cnt <= (r_in_cnt == r_src_max) ? 9'd0 : r_in_cnt + 9'd1;
                        if (r_in_cnt == r_src_max && r_b_in == r_b_max) r_st <= DRAIN;
                        else if (r_in_cnt == r_src_max) begin
                            r_b_in <= w_b_in_nx;
                            r_last <= w_b_in_nx == r_b_max;
                        end
                    end
                    if (w_out_beat) r_out_cnt <= w_out_wrap ? 9'd0 : r_out_cnt + 9'd1;
                    if (w_out_wrap && !w_to_done) r_b_out <= r_b_out + BW'(1);
                    if (w_to_done) begin
                        r_st   <= DONE;
                        r_run  <= 1'b0;
                        r_last <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_st   <= IDLE;
                    r_busy <= 1'b0;
                end
                default: r_st <= IDLE;
            endcase
        end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] r_cyc, r_perf_cyc, r_perf_stall;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {r_cyc, r_perf_cyc, r_perf_stall} <= '0;
        else if (w_pop) {r_cyc, r_perf_cyc, r_perf_stall} <= '0;
        else begin
            if (r_st inside {LOAD, GAP, RUN, DRAIN}) r_cyc <= sat_inc(r_cyc);
            if (w_to_done) r_perf_cyc <= sat_inc(r_cyc);
            if (w_act && bus.src_valid && !bus.src_ready) r_perf_stall <= sat_inc(r_perf_stall);
        end
    assign bus.perf_cyc   = r_perf_cyc;
    assign bus.perf_stall = r_perf_stall;
`endif

    assign bus.cmd_ready  = ~w_full;
    assign bus.out_ch     = r_out_ch;
    assign bus.src_a_max  = r_src_max;
    assign bus.dst_a_max  = r_dst_max;
    assign bus.matw       = r_matw;
    assign bus.run        = r_run;
    assign bus.last       = r_last;
    assign bus.busy       = r_busy;
    assign bus.layer_done = r_done;
    assign bus.ovr        = r_ovr;
endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: directed checks of the layer sequencer, sampled on the falling clock edge.
module tb_layer_seq;
    import layer_seq_pkg::*;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0, bad = 0, done_cnt = 0, stall_cnt = 0, base = 0, sbase = 0;
    bit   rnd = 1'b0;
    always #5 clk = ~clk;

    layer_seq_if bus();
    layer_seq #(.DEPTH(4), .BW(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always @(posedge clk) begin
        if (bus.layer_done) done_cnt++;
        if (bus.run && bus.src_valid && !bus.src_ready) stall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic layer_desc_t mk(input int oc, input int src, input int dst, input int w, input int b);
        return '{out_ch: 5'(oc), src_a_max: 9'(src), dst_a_max: 9'(dst), w_max: 10'(w), b_max: 8'(b)};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (rnd) begin
                bus.src_ready = 1'($urandom_range(0, 1));
                bus.dst_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic push(input layer_desc_t d);
        bus.cmd_desc  = d;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++)
            if (bus.layer_done) seen = 1'b1;
            else tick();
        check(tag, 32'(seen), 1);
    endtask

    task automatic wait_matw(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++)
            if (bus.matw) seen = 1'b1;
            else tick();
        check(tag, 32'(seen), 1);
    endtask

    initial begin
        bus.abort = 0; bus.cmd_valid = 0; bus.cmd_desc = '0;
        bus.src_valid = 0; bus.src_ready = 1; bus.dst_valid = 0; bus.dst_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_run_matw", {bus.run, bus.matw, bus.last, bus.layer_done, bus.ovr}, 0);
        reset_n = 1'b1;
        tick();
        check("rel_cmd_ready", 32'(bus.cmd_ready), 1);

        // layer with w_max=5, 2 batches of 8 in / 4 out
        push(mk(3, 7, 3, 5, 1));
        check("t1_idle_after_push", 32'(bus.busy), 0);
        tick();
        check("t1_load", {bus.matw, bus.busy, bus.run}, 3'b110);
        check("t1_desc", {bus.out_ch, bus.src_a_max, bus.dst_a_max}, {5'd3, 9'd7, 9'd3});
        bus.src_valid = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("t1_matw_6th", 32'(bus.matw), 1);
            tick();
        end
        bus.src_valid = 0;
        check("t1_gap", {bus.matw, bus.run}, 0);
        tick();
        check("t1_run", {bus.run, bus.last}, 2'b10);
        bus.src_valid = 1; bus.src_ready = 0;
        tick(3);
        bus.src_ready = 1;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) check("t1_last_pre8", 32'(bus.last), 0);
            if (i == 8) check("t1_last_post8", 32'(bus.last), 1);
            tick();
        end
        bus.src_valid = 0;
        check("t1_drain", {bus.run, bus.last, bus.ovr}, 3'b110);
        bus.dst_valid = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t1_not_done_yet", 32'(bus.layer_done), 0);
            tick();
        end
        check("t1_done", {bus.layer_done, bus.run, bus.last, bus.busy}, 4'b1001);
`ifdef LAYER_SEQ_PERF_EN
        check("t1_perf_cyc", bus.perf_cyc, 34);
        check("t1_perf_stall", bus.perf_stall, 3);
`endif
        bus.dst_valid = 0;
        tick();
        check("t1_idle", {bus.layer_done, bus.busy}, 0);

        // second descriptor queued during RUN of the first
        base = done_cnt;
        push(mk(1, 1, 1, 1, 0));
        tick();
        bus.src_valid = 1;
        tick(2);
        bus.src_valid = 0;
        tick();
        check("t2_runA", 32'(bus.run), 1);
        push(mk(2, 1, 1, 1, 0));
        bus.src_valid = 1; bus.dst_valid = 1;
        wait_done("t2_doneA");
        check("t2_chA", 32'(bus.out_ch), 1);
        tick();
        check("t2_gap_idle", {bus.busy, bus.matw}, 0);
        tick();
        check("t2_loadB", {bus.matw, bus.out_ch}, {1'b1, 5'd2});
        wait_done("t2_doneB");
        bus.src_valid = 0; bus.dst_valid = 0;
        tick();
        check("t2_two_done", 32'(done_cnt - base), 2);
        check("t2_no_ovr", 32'(bus.ovr), 0);

        // b_max=0 single beat layer
        push(mk(4, 0, 0, 0, 0));
        tick();
        bus.src_valid = 1;
        tick();
        bus.src_valid = 0;
        check("t3_gap", 32'(bus.matw), 0);
        tick();
        check("t3_run_last", {bus.run, bus.last}, 2'b11);
        bus.src_valid = 1;
        tick();
        bus.src_valid = 0;
        check("t3_drain", {bus.run, bus.last, bus.layer_done}, 3'b110);
        bus.dst_valid = 1;
        tick();
        bus.dst_valid = 0;
        check("t3_done", {bus.layer_done, bus.run}, 2'b10);
        tick();

        // abort mid-RUN with two queued descriptors
        base = done_cnt;
        push(mk(5, 3, 3, 0, 2));
        tick();
        push(mk(6, 1, 1, 1, 1));
        push(mk(7, 1, 1, 1, 1));
        bus.src_valid = 1;
        tick();
        bus.src_valid = 0;
        tick();
        bus.src_valid = 1;
        tick(2);
        bus.src_valid = 0;
        check("t4_pre_abort", 32'(bus.run), 1);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        check("t4_abort", {bus.run, bus.busy, bus.matw, bus.last, bus.layer_done}, 0);
        check("t4_ready", 32'(bus.cmd_ready), 1);
        tick(3);
        check("t4_flushed", 32'(bus.busy), 0);
        check("t4_no_done", 32'(done_cnt - base), 0);

        // extra input beat in DRAIN raises sticky ovr
        push(mk(8, 1, 1, 0, 0));
        tick();
        bus.src_valid = 1;
        tick();
        bus.src_valid = 0;
        tick();
        bus.src_valid = 1;
        tick(2);
        check("t5_drain_no_ovr", {bus.run, bus.ovr}, 2'b10);
        tick();
        bus.src_valid = 0;
        check("t5_ovr", 32'(bus.ovr), 1);
        bus.dst_valid = 1;
        tick(2);
        bus.dst_valid = 0;
        check("t5_done_ovr", {bus.layer_done, bus.ovr}, 2'b11);
        tick();
        check("t5_ovr_sticky", {bus.busy, bus.ovr}, 2'b01);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        check("t5_ovr_cleared", 32'(bus.ovr), 0);

        // fill the FIFO behind a stalled layer, then run all with random stalls
        base = done_cnt;
        push(mk(0, 1, 1, 1, 1));
        tick();
        for (int i = 1; i <= 4; i++) begin
            check("t6_ready_open", 32'(bus.cmd_ready), 1);
            push(mk(i, 1, 1, 1, 1));
        end
        check("t6_full", 32'(bus.cmd_ready), 0);
        push(mk(9, 1, 1, 1, 1));
        rnd = 1; bus.src_valid = 1; bus.dst_valid = 1;
        for (int k = 0; k <= 4; k++) begin
            wait_matw("t6_load_seen");
            check("t6_order", 32'(bus.out_ch), k);
            sbase = stall_cnt;
            wait_done("t6_layer_done");
`ifdef LAYER_SEQ_PERF_EN
            check("t6_perf_stall", bus.perf_stall, 32'(stall_cnt - sbase));
`endif
        end
        rnd = 0; bus.src_valid = 0; bus.dst_valid = 0; bus.src_ready = 1; bus.dst_ready = 1;
        tick(4);
        check("t6_dropped_5th", 32'(bus.busy), 0);
        check("t6_done_count", 32'(done_cnt - base), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
